// File: rtl/cnn_pkg.sv
// Shared definitions for the Conv1d input-side feeder: FSM state encoding,
// default sequence geometry and small width helpers.
package cnn_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_W_EN   = 3'd1,
    ST_W_SEND = 3'd2,
    ST_D_WAIT = 3'd3,
    ST_D_EN   = 3'd4,
    ST_D_SEND = 3'd5,
    ST_DONE   = 3'd6
  } feeder_state_e;

  localparam int SEQ_LEN_DEF = 8;
  localparam int MAXPOOL_DEF = 2;
  localparam int N_BURST     = SEQ_LEN_DEF / MAXPOOL_DEF;

  // Number of compute bursts in one sequence.
  function automatic int n_bursts(input int seq_len, input int max_pool);
    return seq_len / max_pool;
  endfunction

  // Bits needed to hold any value in 0..max_val.
  function automatic int cnt_w(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/feeder_fetch.sv
// Single-word fetch engine: issues one memory read, captures the word one
// cycle later and holds it on o_data/o_stb until the consumer accepts it.
module feeder_fetch #(
  parameter int BW = 32,
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          RST,
  input  logic          rd_req,
  input  logic [AW-1:0] rd_addr,
  output logic          o_rd,
  output logic [AW-1:0] o_addr,
  input  logic [BW-1:0] i_rdata,
  input  logic          i_ack,
  output logic [BW-1:0] o_data,
  output logic          o_stb,
  output logic          xfer
);

  logic          pend_reg;
  logic          stb_reg;
  logic [BW-1:0] data_reg;
  logic          issue;

  // Only one word is ever in flight: no new read until the held word is taken.
  assign issue  = rd_req & ~pend_reg & ~stb_reg;
  assign o_rd   = issue;
  assign o_addr = issue ? rd_addr : '0;
  assign xfer   = stb_reg & i_ack;
  assign o_data = data_reg;
  assign o_stb  = stb_reg;

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      pend_reg <= 1'b0;
      stb_reg  <= 1'b0;
      data_reg <= '0;
    end else begin
      pend_reg <= issue;
      if (pend_reg) begin
        data_reg <= i_rdata;
        stb_reg  <= 1'b1;
      end else if (xfer) begin
        stb_reg  <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/conv1d_feeder.sv
// Conv1d stream source: optional weight-load burst (taps sent high to low),
// then one compute burst of MaxPool samples per pooling group, then done.
module conv1d_feeder
  import cnn_pkg::*;
#(
  parameter int DW      = 32,
  parameter int in_ch   = 1,
  parameter int size_k  = 3,
  parameter int MaxPool = 2,
  parameter int seq_len = 8,
  parameter int AW      = 10,
  parameter int W_BASE  = 0,
  parameter int D_BASE  = 16
) (
  input  logic                clk,
  input  logic                RST,
  input  logic                i_start,
  input  logic                i_load_w,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_rd,
  output logic [AW-1:0]       o_addr,
  input  logic [DW*in_ch-1:0] i_rdata,
  output logic                o_EN_w,
  output logic                o_EN_c,
  input  logic                i_conv_busy,
  output logic [DW*in_ch-1:0] o_data,
  output logic                o_stb,
  input  logic                i_ack
);

  localparam int BW    = DW * in_ch;
  localparam int NB    = n_bursts(seq_len, MaxPool);
  localparam int WMAX  = (size_k > MaxPool) ? size_k : MaxPool;
  localparam int WC_W  = cnt_w(WMAX - 1);
  localparam int BC_W  = cnt_w(NB);

  localparam logic [WC_W-1:0] W_LAST = WC_W'(size_k - 1);
  localparam logic [WC_W-1:0] D_LAST = WC_W'(MaxPool - 1);
  localparam logic [BC_W-1:0] B_ALL  = BC_W'(NB);
  localparam logic [AW-1:0]   W_TOP  = AW'(W_BASE + size_k - 1);
  localparam logic [AW-1:0]   D_ORG  = AW'(D_BASE);

  feeder_state_e   state_reg, state_next;
  logic [WC_W-1:0] word_cnt_reg, word_cnt_next;
  logic [BC_W-1:0] burst_cnt_reg, burst_cnt_next;
  logic [15:0]     sample_ptr_reg, sample_ptr_next;

  logic            rd_req;
  logic [AW-1:0]   rd_addr;
  logic            xfer;
  logic            en_w;
  logic            en_c;
  logic            done;

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state_reg      <= ST_IDLE;
      word_cnt_reg   <= '0;
      burst_cnt_reg  <= '0;
      sample_ptr_reg <= '0;
    end else begin
      state_reg      <= state_next;
      word_cnt_reg   <= word_cnt_next;
      burst_cnt_reg  <= burst_cnt_next;
      sample_ptr_reg <= sample_ptr_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    word_cnt_next   = word_cnt_reg;
    burst_cnt_next  = burst_cnt_reg;
    sample_ptr_next = sample_ptr_reg;
    rd_req          = 1'b0;
    rd_addr         = W_TOP - AW'(word_cnt_reg);
    en_w            = 1'b0;
    en_c            = 1'b0;
    done            = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        word_cnt_next   = '0;
        burst_cnt_next  = '0;
        sample_ptr_next = '0;
        if (i_start) begin
          state_next = i_load_w ? ST_W_EN : ST_D_WAIT;
        end
      end

      ST_W_EN: begin
        if (!i_conv_busy) begin
          en_w       = 1'b1;
          state_next = ST_W_SEND;
        end
      end

      // Highest tap first so the Conv1d shift chain ends with tap k = mem[W_BASE+k].
      ST_W_SEND: begin
        rd_req  = 1'b1;
        rd_addr = W_TOP - AW'(word_cnt_reg);
        if (xfer) begin
          if (word_cnt_reg == W_LAST) begin
            word_cnt_next = '0;
            state_next    = ST_D_WAIT;
          end else begin
            word_cnt_next = word_cnt_reg + 1'b1;
          end
        end
      end

      ST_D_WAIT: begin
        state_next = (burst_cnt_reg == B_ALL) ? ST_DONE : ST_D_EN;
      end

      // Waiting on i_conv_busy here also absorbs the Conv1d MULT/ADD latency.
      ST_D_EN: begin
        if (!i_conv_busy) begin
          en_c       = 1'b1;
          state_next = ST_D_SEND;
        end
      end

      ST_D_SEND: begin
        rd_req  = 1'b1;
        rd_addr = D_ORG + AW'(sample_ptr_reg);
        if (xfer) begin
          sample_ptr_next = sample_ptr_reg + 16'd1;
          if (word_cnt_reg == D_LAST) begin
            word_cnt_next  = '0;
            burst_cnt_next = burst_cnt_reg + 1'b1;
            state_next     = ST_D_WAIT;
          end else begin
            word_cnt_next  = word_cnt_reg + 1'b1;
          end
        end
      end

      ST_DONE: begin
        done            = 1'b1;
        word_cnt_next   = '0;
        burst_cnt_next  = '0;
        sample_ptr_next = '0;
        state_next      = ST_IDLE;
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  feeder_fetch #(
    .BW (BW),
    .AW (AW)
  ) u_fetch (
    .clk     (clk),
    .RST     (RST),
    .rd_req  (rd_req),
    .rd_addr (rd_addr),
    .o_rd    (o_rd),
    .o_addr  (o_addr),
    .i_rdata (i_rdata),
    .i_ack   (i_ack),
    .o_data  (o_data),
    .o_stb   (o_stb),
    .xfer    (xfer)
  );

  assign o_busy = (state_reg != ST_IDLE);
  assign o_done = done;
  assign o_EN_w = en_w;
  assign o_EN_c = en_c;

endmodule

// File: tb/tb_conv1d_feeder.sv
// Directed bench for conv1d_feeder with a memory model and a Conv1d model.
module tb_conv1d_feeder;

  localparam int DW = 8;
  localparam int IN_CH = 1;
  localparam int SIZE_K = 3;
  localparam int MP = 2;
  localparam int SEQ = 8;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          RST = 1'b1;
  logic          i_start = 1'b0;
  logic          i_load_w = 1'b0;
  logic          i_ack = 1'b0;
  logic          i_conv_busy;
  logic          o_busy, o_done, o_rd, o_EN_w, o_EN_c, o_stb;
  logic [AW-1:0] o_addr;
  logic [7:0]    rdata;
  logic [7:0]    o_data;

  logic [7:0]    mem [0:1023];

  always #5 clk = ~clk;

  conv1d_feeder #(
    .DW(DW), .in_ch(IN_CH), .size_k(SIZE_K), .MaxPool(MP), .seq_len(SEQ),
    .AW(AW), .W_BASE(0), .D_BASE(16)
  ) dut (
    .clk(clk), .RST(RST), .i_start(i_start), .i_load_w(i_load_w),
    .o_busy(o_busy), .o_done(o_done), .o_rd(o_rd), .o_addr(o_addr),
    .i_rdata(rdata), .o_EN_w(o_EN_w), .o_EN_c(o_EN_c),
    .i_conv_busy(i_conv_busy), .o_data(o_data), .o_stb(o_stb), .i_ack(i_ack)
  );

  // Synchronous single-port buffer memory.
  always @(posedge clk) if (o_rd) rdata <= mem[o_addr];

  // Conv1d model: taps shift in at tap 0; busy from EN_c until 4 cycles after the burst.
  logic       wmode;
  int         words, cd;
  logic [7:0] tap0, tap1, tap2;
  always @(posedge clk or posedge RST) begin
    if (RST) begin
      i_conv_busy <= 1'b0; wmode <= 1'b0; words <= 0; cd <= 0;
      tap0 <= '0; tap1 <= '0; tap2 <= '0;
    end else begin
      if (o_EN_w) wmode <= 1'b1;
      if (o_EN_c) begin wmode <= 1'b0; i_conv_busy <= 1'b1; words <= 0; end
      if (o_stb && i_ack) begin
        if (wmode) begin tap0 <= o_data; tap1 <= tap0; tap2 <= tap1; end
        else begin
          words <= words + 1;
          if (words == MP - 1) cd <= 4;
        end
      end
      if (cd != 0) begin
        cd <= cd - 1;
        if (cd == 1) i_conv_busy <= 1'b0;
      end
    end
  end

  // Monitor on the falling edge: logs transfers, reads, pulses and protocol violations.
  int            en_w_cnt = 0, en_c_cnt = 0, done_cnt = 0, viol = 0;
  logic [7:0]    xq[$];
  logic [AW-1:0] aq[$];
  always @(negedge clk) begin
    if (!RST) begin
      if (o_stb && i_ack) begin
        xq.push_back(o_data);
        $display("XFER data=%0d time=%0t", o_data, $time);
      end
      if (o_rd) aq.push_back(o_addr);
      if (o_EN_w) en_w_cnt <= en_w_cnt + 1;
      if (o_EN_c) en_c_cnt <= en_c_cnt + 1;
      if (o_done) done_cnt <= done_cnt + 1;
      if (((o_EN_w || o_EN_c) && (i_conv_busy || o_stb)) || (o_EN_w && o_EN_c))
        viol <= viol + 1;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_busy"}, o_busy, 0);
    check({tag, "_done"}, o_done, 0);
    check({tag, "_rd"}, o_rd, 0);
    check({tag, "_addr"}, o_addr, 0);
    check({tag, "_en_w"}, o_EN_w, 0);
    check({tag, "_en_c"}, o_EN_c, 0);
    check({tag, "_data"}, o_data, 0);
    check({tag, "_stb"}, o_stb, 0);
  endtask

  task automatic wait_done(input int budget);
    int base;
    base = done_cnt;
    for (int i = 0; i < budget; i++) begin
      if (done_cnt != base) break;
      tick();
    end
  endtask

  task automatic start_seq(input logic lw);
    i_load_w = lw;
    i_start  = 1'b1;
    tick();
    i_start  = 1'b0;
    i_load_w = 1'b0;
  endtask

  // Checks an 8-word data-only sequence logged from the given queue positions.
  task automatic check_data_run(input string tag, input int bx, input int ba);
    check({tag, "_nwords"}, xq.size() - bx, 8);
    check({tag, "_nreads"}, aq.size() - ba, 8);
    for (int j = 0; j < 8; j++) begin
      check({tag, "_word"}, (bx + j < xq.size()) ? 32'(xq[bx + j]) : 32'hFFFF, 10 + j);
      check({tag, "_addr"}, (ba + j < aq.size()) ? 32'(aq[ba + j]) : 32'hFFFF, 16 + j);
    end
  endtask

  initial begin
    int bx, ba, bw, bc, bd;
    for (int i = 0; i < 1024; i++) mem[i] = 8'hEE;
    mem[0] = 8'd1; mem[1] = 8'd2; mem[2] = 8'd3;
    for (int i = 0; i < 8; i++) mem[16 + i] = 8'(10 + i);

    // Reset state
    RST = 1'b1;
    repeat (3) tick();
    check_quiet("reset");
    RST = 1'b0;
    tick();

    // Weights then data, with backpressure on the first word and a stray start
    i_ack = 1'b0;
    start_seq(1'b1);
    for (int i = 0; i < 20; i++) begin
      if (o_stb) break;
      tick();
    end
    check("bp_stb_up", o_stb, 1);
    check("bp_first_word", o_data, 3);
    check("bp_en_w_once", en_w_cnt, 1);
    i_start = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      i_start = 1'b0;
      check("bp_hold_data", o_data, 3);
      check("bp_hold_stb", o_stb, 1);
    end
    check("bp_no_xfer", xq.size(), 0);
    i_ack = 1'b1;
    tick();
    tick();
    check("bp_one_xfer", xq.size(), 1);
    check("bp_stb_dropped", o_stb, 0);
    wait_done(300);
    check("w_done_cnt", done_cnt, 1);
    check("w_en_w_cnt", en_w_cnt, 1);
    check("w_en_c_cnt", en_c_cnt, 4);
    check("w_nwords", xq.size(), 11);
    check("w_nreads", aq.size(), 11);
    for (int j = 0; j < 11; j++) begin
      check("w_word", (j < xq.size()) ? 32'(xq[j]) : 32'hFFFF, (j < 3) ? 3 - j : 7 + j);
      check("w_addr", (j < aq.size()) ? 32'(aq[j]) : 32'hFFFF, (j < 3) ? 2 - j : 13 + j);
    end
    check("tap0", tap0, 1);
    check("tap1", tap1, 2);
    check("tap2", tap2, 3);
    check("w_busy_after", o_busy, 0);
    check("w_done_low", o_done, 0);

    // Data only
    bx = xq.size(); ba = aq.size(); bw = en_w_cnt; bc = en_c_cnt; bd = done_cnt;
    start_seq(1'b0);
    wait_done(300);
    check("d_done_cnt", done_cnt - bd, 1);
    check("d_no_en_w", en_w_cnt - bw, 0);
    check("d_en_c_cnt", en_c_cnt - bc, 4);
    check_data_run("d", bx, ba);
    check("d_busy_after", o_busy, 0);

    // Reset during the second data burst, then replay from sample 0
    bx = xq.size(); bc = en_c_cnt; bd = done_cnt;
    start_seq(1'b0);
    for (int i = 0; i < 200; i++) begin
      if (xq.size() - bx >= 3) break;
      tick();
    end
    check("mid_en_c_cnt", en_c_cnt - bc, 2);
    check("mid_busy", o_busy, 1);
    RST = 1'b1;
    #1;
    check_quiet("midrst");
    tick();
    tick();
    RST = 1'b0;
    tick();
    check("midrst_no_done", done_cnt - bd, 0);
    bx = xq.size(); ba = aq.size(); bc = en_c_cnt; bd = done_cnt;
    start_seq(1'b0);
    wait_done(300);
    check("re_done_cnt", done_cnt - bd, 1);
    check("re_en_c_cnt", en_c_cnt - bc, 4);
    check_data_run("re", bx, ba);

    check("protocol_violations", viol, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/conv1d_feeder.md
Name: conv1d_feeder

Overview:
Stream source for the Conv1d input port. It reads kernel weights and input samples from a synchronous single-port buffer memory and drives the Conv1d load/compute enables and the input stb/ack handshake. For each sequence it optionally performs one weight-load burst, then issues one compute burst per pooling group. It finishes with a done pulse to the layer controller.

Parameters:
DW, 32, word width per channel
in_ch, 1, channels per transfer word (bus width DW*in_ch)
size_k, 3, kernel taps = words per weight burst
MaxPool, 2, samples per compute burst
seq_len, 8, samples per sequence; must be a multiple of MaxPool
AW, 10, memory address width
W_BASE, 0, address of weight tap 0
D_BASE, 16, address of sample 0

Ports:
clk  in  1  clock
RST  in  1  asynchronous active-high reset
i_start  in  1  one-cycle start pulse
i_load_w  in  1  sampled with i_start: 1 = load weights before data
o_busy  out  1  high whenever state != IDLE
o_done  out  1  one-cycle pulse at sequence end
o_rd  out  1  memory read enable
o_addr  out  AW  memory read address
i_rdata  in  DW*in_ch  read data, valid the cycle after o_rd
o_EN_w  out  1  Conv1d weight-load enable pulse
o_EN_c  out  1  Conv1d compute enable pulse
i_conv_busy  in  1  Conv1d busy
o_data  out  DW*in_ch  word to Conv1d
o_stb  out  1  o_data valid
i_ack  in  1  Conv1d accept

Behaviour:
- Clock and reset: one clock clk; reset RST is asynchronous and active-high. While RST is high: state=IDLE, all outputs 0, all counters 0. Reset mid-burst abandons the burst with no cleanup.
- States: IDLE, W_EN, W_SEND, D_WAIT, D_EN, D_SEND, DONE.
- IDLE:
  - i_start=1 latches i_load_w.
  - Next state is W_EN if i_load_w=1, else D_WAIT.
  - i_start is ignored in every other state.
- W_EN: wait for i_conv_busy=0, then assert o_EN_w for exactly one cycle and enter W_SEND.
- D_EN: same as W_EN, but drives o_EN_c.
- o_EN_w and o_EN_c are never high together, and never high while o_stb=1.
- Word fetch, in both SEND states:
  - Cycle c: o_rd=1 with the address.
  - Edge after cycle c+1: o_data<=i_rdata and o_stb<=1.
- Handshake:
  - A transfer occurs at a rising edge where o_stb=1 and i_ack=1.
  - o_stb and o_data hold unchanged until that transfer.
  - o_stb goes to 0 on the transfer edge.
  - The next fetch starts the following cycle.
  - o_stb is never raised again until new data is loaded.
  - Resulting rate: one word per 3 cycles minimum.
- Weight order: addresses W_BASE+size_k-1 down to W_BASE. Because Conv1d shifts each new weight in at tap 0, this leaves tap k = mem[W_BASE+k].
  - After size_k transfers, go to D_WAIT.
- Data order: ascending from D_BASE. A 16-bit sample pointer persists across bursts within the sequence.
  - Each D_SEND burst sends exactly MaxPool words, then goes to D_WAIT.
- D_WAIT:
  - If bursts sent = seq_len/MaxPool, go to DONE.
  - Otherwise go to D_EN. D_EN itself waits for i_conv_busy=0, which covers the Conv1d MULT/ADD/WAIT period.
- DONE: o_done=1 for one cycle, clear counters, go to IDLE.
- Priming is not handled here: the first ceil((size_k-1)/MaxPool) Conv1d outputs contain zero-padded history, and the downstream block discards them.
- Address arithmetic: o_addr is AW bits and wraps modulo 2^AW with no error.

Decomposition:
- Shared package cnn_pkg holds the state encodings, a localparam N_BURST = seq_len/MaxPool, and the width helpers.
- One sub-module is natural: feeder_fetch. It owns o_rd, the 1-cycle read-latency capture and the o_stb/o_data hold register.
- The FSM and address counters stay in the top level.

Test Plan:
All scenarios use DW=8, in_ch=1, size_k=3, MaxPool=2, seq_len=8 with a Conv1d behavioural model attached.
- Weights: mem[0..2]=1,2,3, i_load_w=1 -> one o_EN_w pulse; words sent 3,2,1; model taps {1,2,3}.
- Data: mem[16..23]=10..17 -> four o_EN_c pulses, each after i_conv_busy=0; words 10,11 | 12,13 | 14,15 | 16,17. o_done pulses once, after the last burst, then o_busy=0.
- Backpressure: hold i_ack low for 5 cycles with o_stb=1 -> o_data unchanged and exactly one transfer; o_EN_c is not reasserted while i_conv_busy=1.
- i_load_w=0 -> no o_EN_w; only 8 data words sent, with addresses 16..23.
- Reset and re-entry:
  - Assert RST during the 2nd data burst -> all outputs 0 immediately.
  - A new i_start then replays the sequence from sample 0.
  - i_start pulsed while o_busy=1 -> ignored, with no change to counts or the output sequence.
